hc165_reader: RTL
=================

Name: hc165_reader

Overview:
- Serial-input counterpart to the board's 74HC595 output chain.
- Scans a daisy-chain of 74HC165 parallel-in/serial-out registers (switches, DIP banks, extra keys) and delivers the captured word as a parallel register with a one-cycle valid strobe.
- Sits beside the keyboard scanner and seven-segment driver, and feeds top-level key/display logic.

Parameters:
- DATA_W, 16, total chain width in bits (8 per chip); must be >=2.
- CLK_DIV, 25, clk cycles per half-period of sclk_out; also the width of the pl_n_out low pulse; must be >=1.
- GAP_CYC, 50000, idle clk cycles between scans in auto mode; must be >=1.

Ports:
- clk, in, 1, system clock.
- rst, in, 1, asynchronous active-high reset.
- start, in, 1, single-cycle request for one scan; ignored while busy=1.
- auto_en, in, 1, level; when 1, a new scan starts GAP_CYC cycles after the previous scan ends.
- pl_n_out, out, 1, 74HC165 SH/LD (active-low parallel load).
- ce_n_out, out, 1, 74HC165 CLK INH (active-low enable).
- sclk_out, out, 1, 74HC165 CLK.
- sdi_in, in, 1, 74HC165 QH of the last chip; passed through a 2-flop synchronizer.
- data_out, out, DATA_W, last accepted word; the bit first shifted out lands in the MSB.
- data_valid, out, 1, one-cycle pulse when data_out is updated.
- busy, out, 1, high from scan start until the cycle data_valid could fire.

Behaviour:
- Reset values: pl_n_out=1, ce_n_out=1, sclk_out=0, data_out=0, data_valid=0, busy=0, FSM=IDLE, all counters=0.
- Timing base: a tick counter runs 0..CLK_DIV-1. A "tick" is the cycle the counter wraps. The counter is cleared on every state entry.
- IDLE:
  - start=1 -> LOAD, busy=1.
  - With auto_en=1, the gap counter reaching GAP_CYC-1 also -> LOAD.
  - start and auto expiry in the same cycle start one scan only.
- LOAD: pl_n_out=0, ce_n_out=0, for exactly CLK_DIV cycles; then -> SETUP.
- SETUP: pl_n_out=1 for CLK_DIV cycles (hold time); then -> SHIFT_LO, bit counter=0.
- SHIFT_LO: sclk_out=0 for CLK_DIV cycles. On its tick:
  - shreg <= {shreg[DATA_W-2:0], sdi_sync}.
  - If bit counter = DATA_W-1 -> DONE; else -> SHIFT_HI.
- SHIFT_HI: sclk_out=1 for CLK_DIV cycles; bit counter++ on tick; -> SHIFT_LO.
- DONE (1 cycle):
  - ce_n_out=1, busy=0, data_out<=shreg, data_valid=1.
  - -> IDLE; gap counter cleared.
- Edge count: exactly DATA_W-1 sclk rising edges per scan; the first bit is sampled before any edge.
- Scan length: from the cycle after start to the DONE cycle inclusive, CLK_DIV*(2+2*DATA_W-1)+1 cycles.
- Sync latency: the synchronizer adds 2 cycles on sdi_in. The external device output must be stable at least 2 cycles before each tick; CLK_DIV>=3 guarantees this for a zero-delay model.
- Ignored inputs: start during busy is dropped, not queued. auto_en falling mid-scan does not abort the scan.
- Reset mid-scan: all outputs return to reset values immediately, and no partial word is published.
- Glitch-free outputs: pl_n_out, ce_n_out and sclk_out are all registered.

Optional Feature:
- HC165_DEBOUNCE_EN defined:
  - A word is accepted only if it equals the previous scan's raw word.
  - On mismatch, DONE stores the raw word as the new reference and emits no data_valid; data_out holds.
  - The first scan after reset is never accepted.
- Undefined: every scan is accepted, and the reference register is not built.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE, LOAD, SETUP, SHIFT_LO, SHIFT_HI, DONE).
  - Default constants HC165_DATA_W, HC165_CLK_DIV, HC165_GAP_CYC.
- One natural sub-module, tick_gen: parameterised divider with clear input and tick output. It can be reused later by the led_segment serializer.

Test Plan:
- Single scan: DATA_W=8, CLK_DIV=4, model presents 8'hA5, pulse start -> exactly 7 sclk rising edges, pl_n_out low for 4 cycles, data_out=8'hA5 with data_valid for 1 cycle, 4*(2+15)+1=69 cycles after start, busy low on that cycle.
- Chain: DATA_W=16, model chips {8'h3C,8'hC3} -> data_out=16'h3CC3; a second start issued while busy has no effect (one data_valid only).
- Auto mode: auto_en=1, GAP_CYC=10, model changes value between scans -> consecutive data_valid pulses separated by scan length+10 cycles; each data_out matches the model.
- Reset mid-shift: assert rst during SHIFT_HI of bit 3 -> same cycle pl_n_out=1, ce_n_out=1, sclk_out=0, busy=0, data_out=0; the next start yields a correct full word.
- Debounce (HC165_DEBOUNCE_EN): scans read 8'h11, 8'h12, 8'h12 -> no valid after scans 1 and 2, valid with 8'h12 after scan 3.
- Simultaneous start and auto expiry in the same cycle -> exactly one scan, one data_valid.

Source files
------------

// File: rtl/hc165_reader_pkg.sv
// -----------------------------------------------------------------------------
// hc165_reader_pkg
// Shared definitions for the 74HC165 chain reader:
//   - FSM state encoding (legacy-compatible localparam constants)
//   - default parameter values for the reader
//   - cnt_w(): counter width helper that never returns zero
// -----------------------------------------------------------------------------
package hc165_reader_pkg;

  // Scan FSM encoding
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_LOAD     = 3'd1;
  localparam logic [2:0] ST_SETUP    = 3'd2;
  localparam logic [2:0] ST_SHIFT_LO = 3'd3;
  localparam logic [2:0] ST_SHIFT_HI = 3'd4;
  localparam logic [2:0] ST_DONE     = 3'd5;

  // Default configuration: two chips, ~1 MHz sclk at 50 MHz, ~1 ms scan gap
  localparam int HC165_DATA_W  = 16;
  localparam int HC165_CLK_DIV = 25;
  localparam int HC165_GAP_CYC = 50000;

  // Width of a counter that must hold values 0..n-1 (at least one bit)
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hc165_reader_tick_gen.sv
// -----------------------------------------------------------------------------
// tick_gen
// Free-running divider counting 0..DIV-1. o_tick is high during the cycle the
// counter sits at DIV-1 (the wrap cycle). i_clr forces the count back to 0 on
// the next edge, so a client can restart the period on every state entry.
//
// Parameters:
//   DIV     - period in clk cycles (>= 1; DIV=1 ticks every cycle)
// Ports:
//   clk     - system clock
//   rst     - asynchronous active-high reset
//   i_clr   - synchronous restart of the period
//   o_tick  - one-cycle pulse at the end of each period
// -----------------------------------------------------------------------------
module tick_gen
  import hc165_reader_pkg::*;
#(
  parameter int DIV = HC165_CLK_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  output logic o_tick
);

  localparam int            CW   = cnt_w(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours, independent of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr || (r_cnt == LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tick = (r_cnt == LAST);

endmodule

// File: rtl/hc165_reader.sv
// -----------------------------------------------------------------------------
// hc165_reader
// Scans a daisy-chain of 74HC165 PISO registers and publishes the captured
// word on data_out with a one-cycle data_valid strobe. Scans are started by a
// start pulse or, with auto_en high, GAP_CYC idle cycles after the last scan.
//
// Optional build macro:
//   HC165_DEBOUNCE_EN - publish a word only when it equals the raw word of the
//                       previous scan; the first scan after reset is never
//                       published. Undefined: every scan is published.
//
// Parameters:
//   DATA_W  - chain width in bits (8 per chip), >= 2
//   CLK_DIV - clk cycles per sclk half-period and per pl_n low pulse, >= 1
//   GAP_CYC - idle cycles between scans in auto mode, >= 1
// Ports:
//   clk        - system clock
//   rst        - asynchronous active-high reset
//   start      - one-cycle scan request, ignored while busy
//   auto_en    - level, enables periodic scanning
//   pl_n_out   - 74HC165 SH/LD (active-low parallel load)
//   ce_n_out   - 74HC165 CLK INH (active-low clock enable)
//   sclk_out   - 74HC165 CLK
//   sdi_in     - QH of the last chip (asynchronous, synchronised here)
//   data_out   - last accepted word; first bit shifted out lands in the MSB
//   data_valid - one-cycle pulse when data_out updates
//   busy       - high from scan start until the DONE cycle
// -----------------------------------------------------------------------------
module hc165_reader
  import hc165_reader_pkg::*;
#(
  parameter int DATA_W  = HC165_DATA_W,
  parameter int CLK_DIV = HC165_CLK_DIV,
  parameter int GAP_CYC = HC165_GAP_CYC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              auto_en,
  output logic              pl_n_out,
  output logic              ce_n_out,
  output logic              sclk_out,
  input  logic              sdi_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              busy
);

  localparam int            BW       = cnt_w(DATA_W);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);
  localparam int            GW       = cnt_w(GAP_CYC);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);

  logic [2:0]        r_state;
  logic [2:0]        w_next_state;
  logic              w_tick;
  logic              w_auto_fire;
  logic              w_last_tick;
  logic              w_accept;
  logic              w_next_active;
  logic [BW-1:0]     r_bit;
  logic [GW-1:0]     r_gap;
  logic [DATA_W-1:0] r_shreg;
  logic [DATA_W-1:0] w_shift_next;
  logic              r_sdi_meta;
  logic              r_sdi_sync;
  logic              r_pl_n;
  logic              r_active;
  logic              r_sclk;
  logic [DATA_W-1:0] r_data;
  logic              r_valid;

  // ---------------------------------------------------------------------------
  // Two-flop synchroniser on the serial input
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sdi_meta <= 1'b0;
      r_sdi_sync <= 1'b0;
    end else begin
      r_sdi_meta <= sdi_in;
      r_sdi_sync <= r_sdi_meta;
    end
  end

  // ---------------------------------------------------------------------------
  // Phase timing: the divider restarts whenever the FSM changes state, so
  // every phase lasts exactly CLK_DIV cycles.
  // ---------------------------------------------------------------------------
  tick_gen #(
    .DIV (CLK_DIV)
  ) u_tick_gen (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_next_state != r_state),
    .o_tick (w_tick)
  );

  assign w_auto_fire  = auto_en && (r_gap == GAP_LAST);
  assign w_shift_next = {r_shreg[DATA_W-2:0], r_sdi_sync};
  assign w_last_tick  = (r_state == ST_SHIFT_LO) && w_tick && (r_bit == LAST_BIT);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:     if (start || w_auto_fire) w_next_state = ST_LOAD;
      ST_LOAD:     if (w_tick) w_next_state = ST_SETUP;
      ST_SETUP:    if (w_tick) w_next_state = ST_SHIFT_LO;
      ST_SHIFT_LO: if (w_tick) w_next_state = (r_bit == LAST_BIT) ? ST_DONE : ST_SHIFT_HI;
      ST_SHIFT_HI: if (w_tick) w_next_state = ST_SHIFT_LO;
      ST_DONE:     w_next_state = ST_IDLE;
      default:     w_next_state = ST_IDLE;
    endcase
  end

  assign w_next_active = (w_next_state == ST_LOAD)     || (w_next_state == ST_SETUP) ||
                         (w_next_state == ST_SHIFT_LO) || (w_next_state == ST_SHIFT_HI);

  // ---------------------------------------------------------------------------
  // State, bit counter, gap counter and shift register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_bit   <= '0;
      r_gap   <= '0;
      r_shreg <= '0;
    end else begin
      r_state <= w_next_state;

      if (r_state == ST_SETUP) begin
        r_bit <= '0;
      end else if ((r_state == ST_SHIFT_HI) && w_tick) begin
        r_bit <= r_bit + 1'b1;
      end

      // Gap counts only while idle with auto mode on; it restarts after DONE
      // and saturates so a late auto_en cannot wrap it.
      if ((r_state != ST_IDLE) || !auto_en) begin
        r_gap <= '0;
      end else if (r_gap != GAP_LAST) begin
        r_gap <= r_gap + 1'b1;
      end

      if ((r_state == ST_SHIFT_LO) && w_tick) begin
        r_shreg <= w_shift_next;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Acceptance: the word is final on the last SHIFT_LO tick, so publishing it
  // on that edge makes data_out and data_valid visible in the DONE cycle.
  // ---------------------------------------------------------------------------
`ifdef HC165_DEBOUNCE_EN
  logic [DATA_W-1:0] r_ref;
  logic              r_ref_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ref    <= '0;
      r_ref_ok <= 1'b0;
    end else if (w_last_tick) begin
      r_ref    <= w_shift_next;
      r_ref_ok <= 1'b1;
    end
  end

  assign w_accept = w_last_tick && r_ref_ok && (w_shift_next == r_ref);
`else
  assign w_accept = w_last_tick;
`endif

  // ---------------------------------------------------------------------------
  // Registered outputs, decoded from the next state so they line up with the
  // state they belong to without combinational glitches on the pins.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pl_n   <= 1'b1;
      r_active <= 1'b0;
      r_sclk   <= 1'b0;
      r_data   <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_pl_n   <= (w_next_state != ST_LOAD);
      r_active <= w_next_active;
      r_sclk   <= (w_next_state == ST_SHIFT_HI);
      r_valid  <= w_accept;
      if (w_accept) begin
        r_data <= w_shift_next;
      end
    end
  end

  assign pl_n_out   = r_pl_n;
  assign ce_n_out   = ~r_active;
  assign sclk_out   = r_sclk;
  assign busy       = r_active;
  assign data_out   = r_data;
  assign data_valid = r_valid;

endmodule
